// File: rtl/rr_arbiter_4x2.sv
// Four-client round-robin arbiter with grant-hold and bounded-tenure preemption.
// Registered one-hot grant plus its binary index; a sole requester may hold indefinitely.
module rr_arbiter_4x2 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       grant_id_nxt;
    logic             grant_valid_nxt;
    logic             preempt_nxt;

    logic [2:0]       pick_all, pick_oth;
    logic [3:0]       others;
    logic             new_grant;
    logic [1:0]       winner;

    // First set bit of cand scanning from p upward with 2-bit wrap; MSB flags "found".
    function automatic logic [2:0] pick(input logic [3:0] cand, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!res[2] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        others   = req & ~(4'b0001 << owner);
        pick_all = pick(req, ptr);
        pick_oth = pick(others, ptr);
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        owner_nxt       = owner;
        hold_cnt_nxt    = hold_cnt;
        grant_nxt       = grant;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        preempt_nxt     = 1'b0;
        new_grant       = 1'b0;
        winner          = 2'd0;

        case (state)
            IDLE: begin
                if (pick_all[2]) begin
                    new_grant = 1'b1;
                    winner    = pick_all[1:0];
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    if (pick_all[2]) begin
                        new_grant = 1'b1;
                        winner    = pick_all[1:0];
                    end else begin
                        state_nxt       = IDLE;
                        grant_nxt       = 4'b0000;
                        grant_id_nxt    = 2'd0;
                        grant_valid_nxt = 1'b0;
                    end
                end else if (hold_cnt == HOLD_LAST && pick_oth[2]) begin
                    new_grant   = 1'b1;
                    winner      = pick_oth[1:0];
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (new_grant) begin
            state_nxt       = OWNED;
            owner_nxt       = winner;
            hold_cnt_nxt    = '0;
            ptr_nxt         = winner + 2'd1;
            grant_nxt       = 4'b0001 << winner;
            grant_id_nxt    = winner;
            grant_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            owner       <= 2'd0;
            hold_cnt    <= '0;
            grant       <= 4'b0000;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            hold_cnt    <= hold_cnt_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            preempt     <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4x2.sv
// Bench for rr_arbiter_4x2: MAX_HOLD=8 and MAX_HOLD=4 instances share stimulus and are
// checked each cycle against a tenure-based model, plus literal expectations.
module tb_rr_arbiter_4x2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] g   [2];
    logic [1:0] gid [2];
    logic       gv  [2];
    logic       pre [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_4x2 #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[0]), .grant_id(gid[0]), .grant_valid(gv[0]), .preempt(pre[0])
    );

    rr_arbiter_4x2 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[1]), .grant_id(gid[1]), .grant_valid(gv[1]), .preempt(pre[1])
    );

    // Model: owner (-1 = none), priority start, cycles of current tenure, preempt flag.
    int m_owner  [2];
    int m_ptr    [2];
    int m_tenure [2];
    int m_pre    [2];
    int m_max    [2] = '{8, 4};

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (p + i) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic take(input int k, input int w, input int p);
        m_owner[k]  = w;
        m_tenure[k] = 1;
        m_ptr[k]    = (w + 1) % 4;
        m_pre[k]    = p;
    endtask

    task automatic step(input int k);
        int w;
        m_pre[k] = 0;
        if (m_owner[k] < 0) begin
            w = pick(req, m_ptr[k], -1);
            if (w >= 0) take(k, w, 0);
        end else if (!req[m_owner[k]]) begin
            w = pick(req, m_ptr[k], -1);
            if (w >= 0) take(k, w, 0);
            else m_owner[k] = -1;
        end else begin
            w = pick(req, m_ptr[k], m_owner[k]);
            if (m_tenure[k] >= m_max[k] && w >= 0) take(k, w, 1);
            else m_tenure[k]++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_owner[k] = -1; m_ptr[k] = 0; m_tenure[k] = 0; m_pre[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) step(k);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int eg;
                eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
                check($sformatf("model_grant[%0d]", k), int'(g[k]), eg);
                check($sformatf("model_id[%0d]", k), int'(gid[k]), (m_owner[k] >= 0) ? m_owner[k] : 0);
                check($sformatf("model_valid[%0d]", k), int'(gv[k]), (m_owner[k] >= 0) ? 1 : 0);
                check($sformatf("model_preempt[%0d]", k), int'(pre[k]), m_pre[k]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input int k, input int eg, input int eid, input int ep);
        check({name, "_grant"}, int'(g[k]), eg);
        check({name, "_id"}, int'(gid[k]), eid);
        check({name, "_valid"}, int'(gv[k]), (eg != 0) ? 1 : 0);
        check({name, "_preempt"}, int'(pre[k]), ep);
    endtask

    initial begin
        // Reset mid-grant, then restart with client 0.
        cyc(2);
        rst_n = 1'b1;
        req   = 4'b0100;
        cyc(1);
        lit("rst_pre", 0, 4, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        lit("rst_async8", 0, 0, 0, 0);
        lit("rst_async4", 1, 0, 0, 0);
        req = 4'b0001;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        lit("rst_first", 0, 1, 0, 0);
        check("rst_ptr", int'(u_dut8.ptr), 1);

        // Single requester: grant after one edge, drop after release edge.
        req = 4'b0000;
        cyc(1);
        lit("idle", 0, 0, 0, 0);
        req = 4'b0010;
        cyc(1);
        lit("single_on", 0, 2, 1, 0);
        cyc(4);
        req = 4'b0000;
        cyc(1);
        lit("single_off", 0, 0, 0, 0);

        // Back-to-back rotation from reset, two cycles per owner.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            lit($sformatf("rot%0d_a", k), 1, 1 << k, k, 0);
            cyc(1);
            lit($sformatf("rot%0d_b", k), 1, 1 << k, k, 0);
            req[k] = 1'b0;
        end
        cyc(1);
        lit("rot_end", 1, 0, 0, 0);

        // Preemption on the MAX_HOLD=4 instance.
        req = 4'b0001;
        cyc(1);
        lit("pre_own0", 1, 1, 0, 0);
        req = 4'b0101;
        for (int i = 1; i < 4; i++) begin
            cyc(1);
            lit($sformatf("pre_hold%0d", i), 1, 1, 0, 0);
        end
        cyc(1);
        lit("pre_take", 1, 4, 2, 1);
        lit("pre_nopre8", 0, 1, 0, 0);
        cyc(1);
        lit("pre_own2", 1, 4, 2, 0);
        req = 4'b0001;
        cyc(1);
        lit("pre_back", 1, 1, 0, 0);

        // Pointer wrap: 2 -> ptr 3, then 3 wins over 0, then 0 with ptr wrapping to 1.
        req = 4'b0000;
        cyc(1);
        req = 4'b0100;
        cyc(1);
        lit("wrap_c2", 1, 4, 2, 0);
        check("wrap_ptr3", int'(u_dut4.ptr), 3);
        req = 4'b0000;
        cyc(1);
        req = 4'b1001;
        cyc(1);
        lit("wrap_c3", 1, 8, 3, 0);
        req = 4'b0001;
        cyc(1);
        lit("wrap_c0", 1, 1, 0, 0);
        check("wrap_ptr1", int'(u_dut4.ptr), 1);

        // Sole requester holds well past MAX_HOLD without preemption.
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            lit("nocont", 1, 8, 3, 0);
        end
        req = 4'b0000;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
